// File: rtl/multi_port_reg_file.sv
// Register file with one write port, two registered read ports and a sequenced clear sweep.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding; read-first when undefined.
module multi_port_reg_file #(
    parameter int                DATA_W  = 8,
    parameter int                DEPTH   = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int               ADDR_W  = $clog2(DEPTH)
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iClr,
    output logic              oBusy,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    output logic              oWrDrop,
    input  logic              iRdEnA,
    input  logic [ADDR_W-1:0] iRdAddrA,
    output logic [DATA_W-1:0] oRdDataA,
    output logic              oRdValidA,
    input  logic              iRdEnB,
    input  logic [ADDR_W-1:0] iRdAddrB,
    output logic [DATA_W-1:0] oRdDataB,
    output logic              oRdValidB
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;

    // A write is taken only in IDLE on a cycle that does not also start a sweep.
    assign wr_ok = iWrEn && (32'(iWrAddr) < DEPTH) && (state == IDLE) && !iClr;

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
        if (32'(addr) >= DEPTH) begin
            return '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (addr == iWrAddr)) begin
            return iWrData;
        end
        if ((state == CLEAR) && (addr == sweep_cnt)) begin
            return RST_VAL;
        end
`endif
        return mem[addr];
    endfunction

    always_comb begin
        rd_next_a = read_word(iRdAddrA);
        rd_next_b = read_word(iRdAddrB);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            oBusy     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (iClr) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        oBusy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[sweep_cnt] <= RST_VAL;
                    if (sweep_cnt == LAST_ENTRY) begin
                        state     <= IDLE;
                        sweep_cnt <= '0;
                        oBusy     <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (wr_ok) begin
                mem[iWrAddr] <= iWrData;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oWrDrop   <= 1'b0;
            oRdDataA  <= '0;
            oRdValidA <= 1'b0;
            oRdDataB  <= '0;
            oRdValidB <= 1'b0;
        end else begin
            oWrDrop   <= iWrEn && !wr_ok;
            oRdValidA <= iRdEnA;
            oRdValidB <= iRdEnB;
            if (iRdEnA) begin
                oRdDataA <= rd_next_a;
            end
            if (iRdEnB) begin
                oRdDataB <= rd_next_b;
            end
        end
    end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed self-checking bench for multi_port_reg_file; a DEPTH=12 instance shares the
// stimulus to exercise out-of-range addresses.
module tb_multi_port_reg_file;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [3:0] rd_addr_a = '0;
    logic       rd_en_b = 1'b0;
    logic [3:0] rd_addr_b = '0;

    logic       busy, drop, val_a, val_b;
    logic [7:0] rd_a, rd_b;
    logic       busy_12, drop_12, val_a_12, val_b_12;
    logic [7:0] rd_a_12, rd_b_12;

    int checks = 0;
    int failures = 0;

    multi_port_reg_file #(.DATA_W(8), .DEPTH(16), .RST_VAL(8'h00)) dut (
        .iClk(clk), .iRst_n(rst_n), .iClr(clr), .oBusy(busy),
        .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data), .oWrDrop(drop),
        .iRdEnA(rd_en_a), .iRdAddrA(rd_addr_a), .oRdDataA(rd_a), .oRdValidA(val_a),
        .iRdEnB(rd_en_b), .iRdAddrB(rd_addr_b), .oRdDataB(rd_b), .oRdValidB(val_b)
    );

    multi_port_reg_file #(.DATA_W(8), .DEPTH(12), .RST_VAL(8'h00)) dut12 (
        .iClk(clk), .iRst_n(rst_n), .iClr(clr), .oBusy(busy_12),
        .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data), .oWrDrop(drop_12),
        .iRdEnA(rd_en_a), .iRdAddrA(rd_addr_a), .oRdDataA(rd_a_12), .oRdValidA(val_a_12),
        .iRdEnB(rd_en_b), .iRdAddrB(rd_addr_b), .oRdDataB(rd_b_12), .oRdValidB(val_b_12)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Reads every entry of the 16-deep instance through port A; one address may hold a non-zero value.
    task automatic read_all(input string tag, input logic [3:0] hot_addr, input logic [7:0] hot_val);
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 4'(i);
            tick();
            exp = (4'(i) == hot_addr) ? hot_val : 8'h00;
            checks++;
            if (rd_a !== exp || val_a !== 1'b1) begin
                failures++;
                $display("FAIL %s addr=%0d: got data=%h valid=%b expected data=%h valid=1", tag, i, rd_a, val_a, exp);
            end
        end
        rd_en_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || drop !== 1'b0 || rd_a !== 8'h00 || val_a !== 1'b0 || val_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b drop=%b rd_a=%h val_a=%b val_b=%b expected all zero", busy, drop, rd_a, val_a, val_b);
        end
        rst_n = 1'b1;
        tick();
        write_word(4'd1, 8'hC3);
        write_word(4'd7, 8'hC3);
        write_word(4'd15, 8'hC3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        read_all("reset_read_all", 4'd0, 8'h00);
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        tick();
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL wr_accept_drop: got %b expected 0", drop);
        end
        wr_addr = 4'd9; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 4'd3;
        rd_en_b = 1'b1; rd_addr_b = 4'd9;
        tick();
        checks++;
        if (rd_a !== 8'hA5 || val_a !== 1'b1 || rd_b !== 8'h5A || val_b !== 1'b1) begin
            failures++;
            $display("FAIL dual_read: got A=%h/%b B=%h/%b expected A=a5/1 B=5a/1", rd_a, val_a, rd_b, val_b);
        end
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        tick();
        checks++;
        if (rd_a !== 8'hA5 || val_a !== 1'b0 || rd_b !== 8'h5A || val_b !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got A=%h/%b B=%h/%b expected A=a5/0 B=5a/0", rd_a, val_a, rd_b, val_b);
        end
        rd_en_a = 1'b1; rd_addr_a = 4'd9;
        rd_en_b = 1'b1; rd_addr_b = 4'd9;
        tick();
        checks++;
        if (rd_a !== 8'h5A || rd_b !== 8'h5A) begin
            failures++;
            $display("FAIL same_addr_read: got A=%h B=%h expected 5a 5a", rd_a, rd_b);
        end
        rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 8'h22;
`else
        exp = 8'h11;
`endif
        write_word(4'd4, 8'h11);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h22;
        rd_en_a = 1'b1; rd_addr_a = 4'd4;
        tick();
        wr_en = 1'b0;
        checks++;
        if (rd_a !== exp) begin
            failures++;
            $display("FAIL collision_same_cycle: got %h expected %h", rd_a, exp);
        end
        tick();
        rd_en_a = 1'b0;
        checks++;
        if (rd_a !== 8'h22) begin
            failures++;
            $display("FAIL collision_next_cycle: got %h expected 22", rd_a);
        end
    endtask

    task automatic test_clear();
        int         busy_cycles;
        int         guard;
        bit         mid;
        logic [7:0] exp_b;
`ifdef REGFILE_BYPASS_EN
        exp_b = 8'h00;
`else
        exp_b = 8'hFF;
`endif
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 8'hFF);
        end
        clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h99;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || drop !== 1'b1) begin
            failures++;
            $display("FAIL clear_start: got busy=%b drop=%b expected busy=1 drop=1", busy, drop);
        end
        busy_cycles = busy ? 1 : 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            mid = (busy_cycles == 4);
            if (mid) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h33;
                clr = 1'b1;
                rd_en_a = 1'b1; rd_addr_a = 4'd10;
                rd_en_b = 1'b1; rd_addr_b = 4'd3;
            end
            tick();
            guard++;
            wr_en = 1'b0; clr = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
            if (mid) begin
                checks++;
                if (drop !== 1'b1 || rd_a !== 8'hFF || rd_b !== exp_b) begin
                    failures++;
                    $display("FAIL clear_mid_sweep: got drop=%b rd_a=%h rd_b=%h expected drop=1 rd_a=ff rd_b=%h", drop, rd_a, rd_b, exp_b);
                end
            end
            if (busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 16) begin
            failures++;
            $display("FAIL clear_busy_len: got %0d cycles expected 16", busy_cycles);
        end
        write_word(4'd5, 8'h44);
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL clear_first_write: got drop=%b expected 0", drop);
        end
        read_all("clear_read_all", 4'd5, 8'h44);
    endtask

    task automatic test_out_of_range();
        write_word(4'd13, 8'h77);
        checks++;
        if (drop_12 !== 1'b1) begin
            failures++;
            $display("FAIL oor_write_drop: got %b expected 1", drop_12);
        end
        for (int i = 0; i < 12; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 4'(i);
            tick();
            checks++;
            if (rd_a_12 !== ((i == 5) ? 8'h44 : 8'h00)) begin
                failures++;
                $display("FAIL oor_no_change addr=%0d: got %h expected %h", i, rd_a_12, (i == 5) ? 8'h44 : 8'h00);
            end
        end
        rd_addr_a = 4'd5;
        tick();
        rd_addr_a = 4'd13; rd_en_b = 1'b1; rd_addr_b = 4'd13;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        checks++;
        if (rd_a_12 !== 8'h00 || val_a_12 !== 1'b1 || rd_b_12 !== 8'h00 || val_b_12 !== 1'b1) begin
            failures++;
            $display("FAIL oor_read: got A=%h/%b B=%h/%b expected 00/1 00/1", rd_a_12, val_a_12, rd_b_12, val_b_12);
        end
    endtask

    task automatic test_reset_mid_sweep();
        write_word(4'd12, 8'hAB);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || busy_12 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_busy_async: got busy=%b busy_12=%b expected 0 0", busy, busy_12);
        end
        #3;
        rst_n = 1'b1;
        write_word(4'd6, 8'h5C);
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL midrst_write_drop: got %b expected 0", drop);
        end
        read_all("midrst_read_all", 4'd6, 8'h5C);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_clear();
        test_out_of_range();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_port_reg_file.md
# multi_port_reg_file

Parametrised register file: DEPTH entries of DATA_W bits, one write port and two independent registered read ports (A, B). Includes a sequenced clear engine that zeroes the array one entry per cycle on request. Next-generation storage element for datapath blocks that need more than a single holding register, e.g. ALU operand banks and config register banks on Basys3 designs.

## Interface
- DATA_W, 8, entry width in bits
- DEPTH, 16, number of entries (>= 2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- RST_VAL, 0, value loaded into every entry by reset and by clear
- iClk  input  1  clock, rising edge
- iRst_n  input  1  asynchronous reset, active-low
- iClr  input  1  single-cycle request to start a clear sweep
- oBusy  output  1  high while clear sweep is in progress
- iWrEn  input  1  write enable
- iWrAddr  input  ADDR_W  write address
- iWrData  input  DATA_W  write data
- oWrDrop  output  1  one-cycle pulse: a write was discarded
- iRdEnA / iRdEnB  input  1  read enable, port A / B
- iRdAddrA / iRdAddrB  input  ADDR_W  read address, port A / B
- oRdDataA / oRdDataB  output  DATA_W  registered read data
- oRdValidA / oRdValidB  output  1  one-cycle pulse: read data updated

## Operation
- Reset (iRst_n low, async): all entries = RST_VAL; oRdDataA/B = 0; oRdValidA/B = 0; oBusy = 0; oWrDrop = 0; FSM = IDLE; sweep counter = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when iClr = 1; counter loads 0.
  - CLEAR: entry[counter] <= RST_VAL each cycle, counter increments; CLEAR -> IDLE after writing entry DEPTH-1.
  - iClr during CLEAR ignored (no restart).
- Writes in IDLE: iWrEn = 1 and iWrAddr < DEPTH -> entry updated at the clock edge.
- Writes discarded, oWrDrop = 1 the next cycle: iWrEn during CLEAR (including the cycle iClr is sampled in IDLE), or iWrAddr >= DEPTH.
- Reads: iRdEnX = 1 -> oRdDataX <= entry[iRdAddrX], oRdValidX <= 1. iRdEnX = 0 -> oRdDataX holds, oRdValidX <= 0.
- Read of iRdAddrX >= DEPTH -> oRdDataX <= 0, oRdValidX <= 1.
- Both ports may read the same or different addresses in the same cycle; no port conflict exists.
- Reads are permitted during CLEAR; a not-yet-swept entry returns old contents, a swept entry returns RST_VAL.

## Timing
- Read latency: 1 cycle (address sampled at edge N, data/valid visible after edge N).
- Write visible to a read issued the following cycle (read at N+1 returns data written at N).
- Clear sweep: oBusy rises 1 cycle after iClr is sampled and stays high exactly DEPTH cycles; first write accepted on the cycle oBusy is low again.
- Same-cycle read and write to the same address: see Configuration.
- Reset asserted mid-sweep: sweep aborted, array fully at RST_VAL immediately, oBusy = 0.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. A read at edge N to the address being written at edge N returns iWrData. A read at edge N to the entry being cleared at edge N returns RST_VAL.
- Undefined: read-first. The same read returns the entry's old contents; the new value is visible from edge N+1.
- Dropped writes are never forwarded in either mode.

## Test plan
- Reset then read all: iRst_n low, release, read A at addr 0..15 -> every oRdDataA = 0x00, oRdValidA pulses each cycle.
- Write/read both ports: write 0xA5 to addr 3 and 0x5A to addr 9; next cycle A reads 3, B reads 9 -> 0xA5 / 0x5A one cycle later; idle ports hold values with valid = 0.
- Same-cycle collision: entry 4 = 0x11; write 0x22 to 4 while A reads 4 -> 0x22 with REGFILE_BYPASS_EN, 0x11 without; read at the next cycle -> 0x22 in both modes.
- Clear sweep: fill entries with 0xFF, pulse iClr -> oBusy high exactly 16 cycles; write 0x33 to addr 2 mid-sweep -> oWrDrop pulses, entry stays 0; all reads after oBusy drops = 0x00.
- Out-of-range (DEPTH = 12): write 0x77 to addr 13 -> oWrDrop = 1, no entry changes; read addr 13 -> 0x00 with valid = 1.
- Reset mid-sweep: iRst_n low at sweep cycle 5 -> oBusy = 0 immediately, all entries 0x00 after release, subsequent write accepted.
